// File: rtl/div_sequencer_pkg.sv
// riscv_div_pkg: shared types and constants for the RV32M divide unit.
//   XLEN      operand/result width
//   DIV_ITER  number of restoring iterations (one per quotient bit)
//   CNT_W     width of the iteration counter
//   div_cmd_e   command encoding carried on CMD_RD
//   div_state_e sequencer states
package riscv_div_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = XLEN;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Two's complement negation.
    function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
        return '0 - v;
    endfunction

    // Magnitude of v when 'neg' says it is a negative signed value.
    // INT_MIN maps onto itself and is then read as an unsigned 2^(XLEN-1).
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        return neg ? neg_val(v) : v;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: EXE <-> divide-unit handshake bundle.
//   master (EXE side): drives START_DIV, CMD_RD, OP1_SE, OP2_SE, RES_ACK_SE, FLUSH_SM
//   slave  (divider) : drives BUSY_DIV, DONE_DIV, RES_DIV
interface div_sequencer_if;
    import riscv_div_pkg::*;

    logic            START_DIV;
    logic [1:0]      CMD_RD;
    logic [XLEN-1:0] OP1_SE;
    logic [XLEN-1:0] OP2_SE;
    logic            RES_ACK_SE;
    logic            FLUSH_SM;
    logic            BUSY_DIV;
    logic            DONE_DIV;
    logic [XLEN-1:0] RES_DIV;

    modport master (
        output START_DIV, CMD_RD, OP1_SE, OP2_SE, RES_ACK_SE, FLUSH_SM,
        input  BUSY_DIV, DONE_DIV, RES_DIV
    );

    modport slave (
        input  START_DIV, CMD_RD, OP1_SE, OP2_SE, RES_ACK_SE, FLUSH_SM,
        output BUSY_DIV, DONE_DIV, RES_DIV
    );

endinterface

// File: rtl/div_sequencer_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i, quo_i   partial remainder and quotient/dividend shift register
//   divisor_i      unsigned divisor magnitude
//   rem_nxt_o      remainder after the trial subtraction
//   quo_nxt_o      quotient shifted left with the new quotient bit in bit 0
module div_step
    import riscv_div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_nxt_o,
    output logic [XLEN-1:0] quo_nxt_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic [XLEN:0] rem_full;
    logic          borrow;
    logic          unused_rem_msb;

    // The shifted remainder can reach 2*divisor-1, so it needs XLEN+1 bits;
    // the borrow out of the XLEN+1 bit subtraction means trial < 0.
    assign shifted           = {rem_i, quo_i[XLEN-1]};
    assign {borrow, diff}    = {1'b0, shifted} - {2'b00, divisor_i};
    assign rem_full          = borrow ? shifted : diff;
    // Whichever branch is taken is below the divisor, so the top bit is always 0.
    assign unused_rem_msb    = rem_full[XLEN];
    assign rem_nxt_o         = rem_full[XLEN-1:0];
    assign quo_nxt_o         = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: sequencing controller and datapath for DIV/DIVU/REM/REMU.
//   clk      core clock
//   reset_n  synchronous active-low reset
//   bus      div_sequencer_if.slave: START_DIV/CMD_RD/OP1_SE/OP2_SE sampled in IDLE,
//            RES_ACK_SE retires a DONE result, FLUSH_SM aborts;
//            BUSY_DIV (RUN/FIX/DONE), DONE_DIV (DONE), RES_DIV (result, 0 outside DONE)
// Operands are reduced to magnitudes at START, divided unsigned over XLEN
// restoring steps, then sign-corrected in FIX.
module div_sequencer
    import riscv_div_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    div_sequencer_if.slave  bus
);

    div_state_e      state_q, state_d;
    div_cmd_e        cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            is_signed_in;
    logic            sgn1_in;
    logic            sgn2_in;
    logic            cmd_signed_q;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign is_signed_in = ~bus.CMD_RD[0];
    assign sgn1_in      = is_signed_in & bus.OP1_SE[XLEN-1];
    assign sgn2_in      = is_signed_in & bus.OP2_SE[XLEN-1];
    assign cmd_signed_q = ~cmd_q[0];

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_nxt_o (rem_step),
        .quo_nxt_o (quo_step)
    );

    assign quo_fix = (cmd_signed_q & neg_quo_q) ? neg_val(quo_q) : quo_q;
    assign rem_fix = (cmd_signed_q & neg_rem_q) ? neg_val(rem_q) : rem_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.START_DIV) begin
                    cmd_d     = div_cmd_e'(bus.CMD_RD);
                    neg_quo_d = sgn1_in ^ sgn2_in;
                    neg_rem_d = sgn1_in;
                    quo_d     = abs_val(bus.OP1_SE, sgn1_in);
                    dvs_d     = abs_val(bus.OP2_SE, sgn2_in);
                    rem_d     = '0;
                    cnt_d     = CNT_W'(DIV_ITER - 1);
                    state_d   = RUN;
                    if (bus.OP2_SE == '0) begin
                        // RISC-V divide-by-zero: quotient all ones, remainder = dividend.
                        state_d = DONE;
                        res_d   = bus.CMD_RD[1] ? bus.OP1_SE : '1;
                    end else if (is_signed_in && bus.OP1_SE == INT_MIN && bus.OP2_SE == '1) begin
                        // Signed overflow: quotient saturates to INT_MIN, remainder 0.
                        state_d = DONE;
                        res_d   = bus.CMD_RD[1] ? '0 : INT_MIN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                res_d   = cmd_q[1] ? rem_fix : quo_fix;
                state_d = DONE;
            end
            DONE: begin
                if (bus.RES_ACK_SE) begin
                    state_d = IDLE;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over START and ACK arriving in the same cycle.
        if (bus.FLUSH_SM) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    assign busy_d = (state_d != IDLE);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= DIV;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.BUSY_DIV = busy_q;
    assign bus.DONE_DIV = done_q;
    assign bus.RES_DIV  = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer.
// Latency is counted in clock edges after the START edge until DONE_DIV is
// seen: 33 for a normal operation, 0 for the special cases.
module tb_div_sequencer;
    import riscv_div_pkg::*;

    logic clk;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    div_sequencer_if bus();

    div_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        bus.CMD_RD    = cmd;
        bus.OP1_SE    = a;
        bus.OP2_SE    = b;
        bus.START_DIV = 1'b1;
        tick(1);
        bus.START_DIV = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.DONE_DIV !== 1'b1 && lat < 100) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic ack_op;
        bus.RES_ACK_SE = 1'b1;
        tick(1);
        bus.RES_ACK_SE = 1'b0;
    endtask

    // Full transaction: start, wait, capture, acknowledge, capture idle outputs.
    task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res,
                          output logic done_after, output logic [31:0] res_after);
        start_op(cmd, a, b);
        wait_done(lat);
        res = bus.RES_DIV;
        ack_op();
        done_after = bus.DONE_DIV;
        res_after  = bus.RES_DIV;
    endtask

    // Shared by the table-driven tests: run a table of vectors, four checks each.
    task automatic test_table(input string tag, input int n,
                              input logic [1:0] cmds[8], input logic [31:0] as[8],
                              input logic [31:0] bs[8], input logic [31:0] exps[8],
                              input int lats[8]);
        int          lat;
        logic [31:0] res;
        logic        done_after;
        logic [31:0] res_after;
        for (int i = 0; i < n; i++) begin
            run_op(cmds[i], as[i], bs[i], lat, res, done_after, res_after);
            $display("%s[%0d] cmd=%0d a=%h b=%h -> res=%h lat=%0d", tag, i, cmds[i], as[i], bs[i], res, lat);
            total_cnt++;
            if (lat !== lats[i]) $display("FAIL %s_lat[%0d]: got %0d expected %0d", tag, i, lat, lats[i]);
            else pass_cnt++;
            total_cnt++;
            if (res !== exps[i]) $display("FAIL %s_res[%0d]: got %h expected %h", tag, i, res, exps[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_after !== 1'b0) $display("FAIL %s_done_after_ack[%0d]: got %b expected 0", tag, i, done_after);
            else pass_cnt++;
            total_cnt++;
            if (res_after !== 32'h0) $display("FAIL %s_res_after_ack[%0d]: got %h expected 0", tag, i, res_after);
            else pass_cnt++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n        = 1'b0;
        bus.START_DIV  = 1'b0;
        bus.CMD_RD     = 2'b00;
        bus.OP1_SE     = '0;
        bus.OP2_SE     = '0;
        bus.RES_ACK_SE = 1'b0;
        bus.FLUSH_SM   = 1'b0;
        tick(3);
        $display("reset: busy=%b done=%b res=%h", bus.BUSY_DIV, bus.DONE_DIV, bus.RES_DIV);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.BUSY_DIV);
        else pass_cnt++;
        total_cnt++;
        if (bus.DONE_DIV !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.DONE_DIV);
        else pass_cnt++;
        total_cnt++;
        if (bus.RES_DIV !== 32'h0) $display("FAIL reset_res: got %h expected 0", bus.RES_DIV);
        else pass_cnt++;
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_arith;
        logic [1:0]  cmds[8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
        logic [31:0] as[8]   = '{32'd20, 32'hFFFF_FFEC, 32'd100, 32'hFFFF_FFF9,
                                 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[8]   = '{32'd3, 32'd3, 32'd7, 32'd2,
                                 32'd16, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] exps[8] = '{32'd6, 32'hFFFF_FFFA, 32'd14, 32'hFFFF_FFFF,
                                 32'd15, 32'd1, 32'hC000_0000, 32'd0};
        int          lats[8] = '{33, 33, 33, 33, 33, 33, 33, 33};
        test_table("arith", 8, cmds, as, bs, exps, lats);
    endtask

    task automatic test_div_zero;
        logic [1:0]  cmds[8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [31:0] as[8]   = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 0, 0, 0, 0};
        logic [31:0] bs[8]   = '{32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0};
        logic [31:0] exps[8] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0};
        int          lats[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_table("divzero", 4, cmds, as, bs, exps, lats);
    endtask

    task automatic test_overflow;
        logic [1:0]  cmds[8] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [31:0] as[8]   = '{32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0};
        logic [31:0] bs[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
        logic [31:0] exps[8] = '{32'h8000_0000, 32'd0, 0, 0, 0, 0, 0, 0};
        int          lats[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_table("ovf", 2, cmds, as, bs, exps, lats);
    endtask

    task automatic test_flush;
        int          lat;
        logic [31:0] res;
        logic        done_after;
        logic [31:0] res_after;
        // Abort mid-RUN: START at edge T, flush sampled at edge T+10.
        start_op(2'b01, 32'd1000, 32'd10);
        tick(9);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b1) $display("FAIL flush_busy_before: got %b expected 1", bus.BUSY_DIV);
        else pass_cnt++;
        bus.FLUSH_SM = 1'b1;
        tick(1);
        bus.FLUSH_SM = 1'b0;
        $display("flush run: busy=%b done=%b res=%h", bus.BUSY_DIV, bus.DONE_DIV, bus.RES_DIV);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", bus.BUSY_DIV);
        else pass_cnt++;
        tick(1);
        // Restart at T+12; DONE expected 33 edges later.
        run_op(2'b00, 32'd1000, 32'hFFFF_FFF6, lat, res, done_after, res_after);
        $display("flush restart: res=%h lat=%0d", res, lat);
        total_cnt++;
        if (lat !== 33) $display("FAIL flush_restart_lat: got %0d expected 33", lat);
        else pass_cnt++;
        total_cnt++;
        if (res !== 32'hFFFF_FF9C) $display("FAIL flush_restart_res: got %h expected ffffff9c", res);
        else pass_cnt++;

        // Flush and START together in IDLE: flush wins.
        bus.CMD_RD = 2'b01; bus.OP1_SE = 32'd9; bus.OP2_SE = 32'd3;
        bus.START_DIV = 1'b1; bus.FLUSH_SM = 1'b1;
        tick(1);
        bus.START_DIV = 1'b0; bus.FLUSH_SM = 1'b0;
        $display("flush+start: busy=%b", bus.BUSY_DIV);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b0) $display("FAIL flush_beats_start: got %b expected 0", bus.BUSY_DIV);
        else pass_cnt++;

        // Flush and ACK together in DONE: result cleared.
        start_op(2'b01, 32'd5, 32'd0);
        bus.FLUSH_SM = 1'b1; bus.RES_ACK_SE = 1'b1;
        tick(1);
        bus.FLUSH_SM = 1'b0; bus.RES_ACK_SE = 1'b0;
        $display("flush in done: done=%b res=%h", bus.DONE_DIV, bus.RES_DIV);
        total_cnt++;
        if (bus.DONE_DIV !== 1'b0) $display("FAIL flush_done_clear: got %b expected 0", bus.DONE_DIV);
        else pass_cnt++;
        total_cnt++;
        if (bus.RES_DIV !== 32'h0) $display("FAIL flush_res_clear: got %h expected 0", bus.RES_DIV);
        else pass_cnt++;
    endtask

    task automatic test_hold;
        int lat;
        int lat2;
        // ACK asserted during RUN must not disturb the operation.
        start_op(2'b01, 32'd45, 32'd9);
        bus.RES_ACK_SE = 1'b1;
        tick(3);
        bus.RES_ACK_SE = 1'b0;
        wait_done(lat2);
        lat = 3 + lat2;
        $display("hold: res=%h lat=%0d", bus.RES_DIV, lat);
        total_cnt++;
        if (lat !== 33) $display("FAIL hold_lat: got %0d expected 33", lat);
        else pass_cnt++;
        // Hold DONE for 5 cycles while poking START with other operands.
        for (int i = 0; i < 5; i++) begin
            bus.CMD_RD = 2'b01; bus.OP1_SE = 32'd7 + i; bus.OP2_SE = 32'd1;
            bus.START_DIV = (i % 2 == 0);
            tick(1);
            $display("hold[%0d]: done=%b res=%h", i, bus.DONE_DIV, bus.RES_DIV);
            total_cnt++;
            if (bus.DONE_DIV !== 1'b1 || bus.RES_DIV !== 32'd5)
                $display("FAIL hold_stable[%0d]: got done=%b res=%h expected done=1 res=00000005",
                         i, bus.DONE_DIV, bus.RES_DIV);
            else pass_cnt++;
        end
        bus.START_DIV = 1'b0;
        ack_op();
        tick(1);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b0) $display("FAIL hold_idle_after_ack: got %b expected 0", bus.BUSY_DIV);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] res;
        logic        done_after;
        logic [31:0] res_after;
        // run_op issues START in the cycle right after the ACK edge.
        run_op(2'b11, 32'd100, 32'd7, lat, res, done_after, res_after);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, lat, res, done_after, res_after);
        $display("b2b: res=%h lat=%0d", res, lat);
        total_cnt++;
        if (lat !== 33) $display("FAIL b2b_lat: got %0d expected 33", lat);
        else pass_cnt++;
        total_cnt++;
        if (res !== 32'hFFFF_FFFE) $display("FAIL b2b_res: got %h expected fffffffe", res);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        start_op(2'b00, 32'd77, 32'd5);
        tick(5);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(40);
        $display("reset mid-run: busy=%b done=%b", bus.BUSY_DIV, bus.DONE_DIV);
        total_cnt++;
        if (bus.BUSY_DIV !== 1'b0 || bus.DONE_DIV !== 1'b0)
            $display("FAIL reset_mid_run: got busy=%b done=%b expected 0/0", bus.BUSY_DIV, bus.DONE_DIV);
        else pass_cnt++;
        start_op(2'b01, 32'd5, 32'd0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        $display("reset in done: done=%b res=%h", bus.DONE_DIV, bus.RES_DIV);
        total_cnt++;
        if (bus.DONE_DIV !== 1'b0 || bus.RES_DIV !== 32'h0)
            $display("FAIL reset_in_done: got done=%b res=%h expected 0/0", bus.DONE_DIV, bus.RES_DIV);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_arith();
        test_div_zero();
        test_overflow();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
